key_mode_ctrl: RTL and testbench
================================

Name: key_mode_ctrl

Overview:
User-input side of the heartbeat-light design. Takes the raw active-low push button and synchronises and debounces it. Classifies each press as short or long:
- Short press steps the LED mode.
- Long press toggles the LED enable.
It also selects which LED driver's 8-bit pattern reaches the board LEDs.

Parameters:
DEB_CYCLES, 240000, consecutive stable synchronised samples needed to accept a key level change (20 ms at 12 MHz)
LONG_CYCLES, 12000000, debounced hold time in cycles that classifies a press as long (1 s at 12 MHz)
NUM_MODES, 4, number of LED modes, 2..4; mode wraps NUM_MODES-1 -> 0

Ports:
clk  input  1  12 MHz system clock
rst_n  input  1  asynchronous active-low reset
key_n  input  1  raw push button, asynchronous to clk, 0 = pressed
led_m0  input  8  pattern from mode-0 driver
led_m1  input  8  pattern from mode-1 driver
led_m2  input  8  pattern from mode-2 driver
led_m3  input  8  pattern from mode-3 driver
mode  output  2  current mode index
led_en  output  1  1 = LEDs enabled
mode_pulse  output  1  one-cycle strobe when mode changes
long_pulse  output  1  one-cycle strobe when a long press is recognised
led_out  output  8  registered LED pattern to pins

Behaviour:
- Reset (async assert, sync release) values:
  - Sync flops = 1; key_db = 1; debounce and hold counters = 0; FSM = IDLE.
  - mode = 0; led_en = 1; mode_pulse = 0; long_pulse = 0; led_out = 8'h00.
- Synchroniser: two flops on key_n, giving key_s. All logic uses key_s only.
- Debounce:
  - Counter increments each cycle while key_s != key_db.
  - Counter clears in any cycle where key_s == key_db.
  - When the counter is DEB_CYCLES-1 and key_s still != key_db: key_db <= key_s and the counter clears.
  - key_db therefore changes exactly after DEB_CYCLES consecutive differing samples. Any glitch shorter than that is ignored.
  - Press event = key_db 1->0. Release event = key_db 0->1.
- FSM:
  - IDLE: press event -> PRESSED, hold counter = 0.
  - PRESSED: hold counter increments each cycle.
    - Release event before the counter reaches LONG_CYCLES-1 = short press: mode advances, mode_pulse = 1 for one cycle, -> IDLE.
    - Counter reaches LONG_CYCLES-1 = long press: led_en toggles, long_pulse = 1 for one cycle, -> LONG_HELD.
  - LONG_HELD: wait for release event -> IDLE. No mode change.
- Mode arithmetic: mode == NUM_MODES-1 -> 0, else mode+1. No other writers.
- Simultaneous release and long threshold in the same cycle: long wins, FSM -> IDLE directly, mode unchanged.
- Hold counter must be wide enough for LONG_CYCLES (24 bits at default). It saturates and does not wrap.
- led_out registered, 1-cycle latency:
  - led_en = 0 -> led_out = 8'h00.
  - led_en = 1 -> led_out = led_m[mode].
  - Mode change is seen at led_out on the cycle after mode updates.
- Reset mid-press: all state returns to reset values. A button held through reset release is seen as a new press only after DEB_CYCLES of low samples.
- Total press latency, key_n falling to key_db: 2 + DEB_CYCLES cycles.

Test Plan:
All tests use DEB_CYCLES=4, LONG_CYCLES=20, NUM_MODES=4, clk 83.333 ns period, led_m0..3 = 8'h01, 8'h02, 8'h04, 8'h08.
1. Reset: rst_n low 100 ns, then high -> mode=0, led_en=1, pulses 0, led_out=8'h01 two cycles after release.
2. Bounce: key_n low 3 cycles, high 2, low 2, high -> no mode_pulse, mode stays 0, FSM IDLE.
3. Short press: key_n low 10 cycles then high -> exactly one mode_pulse, mode=1, led_out=8'h02. Repeat three more times -> mode 2, 3, then wraps to 0 (led_out 8'h01).
4. Long press: key_n low 40 cycles -> long_pulse once about 26 cycles after falling edge, led_en=0, led_out=8'h00, mode unchanged. Release produces no mode_pulse. A second long press -> led_en=1.
5. Reset mid-press: key_n low 15 cycles, pulse rst_n low, keep key_n low 30 more cycles -> after reset mode=0, led_en=1. The later long_pulse occurs only after a fresh 4+2 debounce plus 20 hold cycles.
6. Boundary: hold chosen so the release event lands on the LONG_CYCLES-1 cycle -> long_pulse, no mode_pulse, FSM IDLE.

Source files
------------

// File: rtl/key_mode_ctrl.sv
// Push-button front end: sync, debounce, short/long press classification,
// LED mode/enable state and the registered LED pattern mux.
`timescale 1ns/1ps
module key_mode_ctrl #(
  parameter int DEB_CYCLES  = 240000,
  parameter int LONG_CYCLES = 12000000,
  parameter int NUM_MODES   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_n,
  input  logic [7:0] led_m0,
  input  logic [7:0] led_m1,
  input  logic [7:0] led_m2,
  input  logic [7:0] led_m3,
  output logic [1:0] mode,
  output logic       led_en,
  output logic       mode_pulse,
  output logic       long_pulse,
  output logic [7:0] led_out
);

  localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam int HW = $clog2(LONG_CYCLES + 1);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);
  localparam logic [HW-1:0] LONG_LAST = HW'(LONG_CYCLES - 1);
  localparam logic [1:0]    MODE_LAST = 2'(NUM_MODES - 1);

  typedef enum logic [1:0] {
    IDLE,
    PRESSED,
    LONG_HELD
  } state_t;

  state_t        state;
  logic          sync0;
  logic          key_s;
  logic          key_db;
  logic [DW-1:0] deb_cnt;
  logic [HW-1:0] hold_cnt;
  logic          deb_fire;
  logic          press_ev;
  logic          release_ev;
  logic [1:0]    mode_next;
  logic [7:0]    led_sel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync0 <= 1'b1;
      key_s <= 1'b1;
    end else begin
      sync0 <= key_n;
      key_s <= sync0;
    end
  end

  // Events fire on the same edge that key_db takes the new level.
  assign deb_fire   = (key_s != key_db) && (deb_cnt == DEB_LAST);
  assign press_ev   = deb_fire & ~key_s;
  assign release_ev = deb_fire & key_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_db  <= 1'b1;
      deb_cnt <= '0;
    end else if (key_s == key_db) begin
      deb_cnt <= '0;
    end else if (deb_cnt == DEB_LAST) begin
      key_db  <= key_s;
      deb_cnt <= '0;
    end else begin
      deb_cnt <= deb_cnt + 1'b1;
    end
  end

  assign mode_next = (mode == MODE_LAST) ? 2'd0 : mode + 2'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      hold_cnt   <= '0;
      mode       <= 2'd0;
      led_en     <= 1'b1;
      mode_pulse <= 1'b0;
      long_pulse <= 1'b0;
    end else begin
      mode_pulse <= 1'b0;
      long_pulse <= 1'b0;
      unique case (state)
        IDLE: begin
          if (press_ev) begin
            state    <= PRESSED;
            hold_cnt <= '0;
          end
        end
        PRESSED: begin
          // Threshold beats a coincident release; the release still ends the press.
          if (hold_cnt == LONG_LAST) begin
            led_en     <= ~led_en;
            long_pulse <= 1'b1;
            state      <= release_ev ? IDLE : LONG_HELD;
          end else if (release_ev) begin
            mode       <= mode_next;
            mode_pulse <= 1'b1;
            state      <= IDLE;
          end else if (hold_cnt < LONG_LAST) begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        LONG_HELD: begin
          if (release_ev) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    led_sel = led_m0;
    unique case (mode)
      2'd1:    led_sel = led_m1;
      2'd2:    led_sel = led_m2;
      2'd3:    led_sel = led_m3;
      default: led_sel = led_m0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) led_out <= 8'h00;
    else        led_out <= led_en ? led_sel : 8'h00;
  end

endmodule

// File: tb/tb_key_mode_ctrl.sv
// Directed bench for key_mode_ctrl with a pulse scoreboard.
`timescale 1ns/1ps
module tb_key_mode_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       key_n = 1'b1;
  logic [7:0] led_m0 = 8'h01;
  logic [7:0] led_m1 = 8'h02;
  logic [7:0] led_m2 = 8'h04;
  logic [7:0] led_m3 = 8'h08;
  logic [1:0] mode;
  logic       led_en;
  logic       mode_pulse;
  logic       long_pulse;
  logic [7:0] led_out;

  always #41.667 clk = ~clk;

  key_mode_ctrl #(
    .DEB_CYCLES (4),
    .LONG_CYCLES(20),
    .NUM_MODES  (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_n     (key_n),
    .led_m0    (led_m0),
    .led_m1    (led_m1),
    .led_m2    (led_m2),
    .led_m3    (led_m3),
    .mode      (mode),
    .led_en    (led_en),
    .mode_pulse(mode_pulse),
    .long_pulse(long_pulse),
    .led_out   (led_out)
  );

  typedef struct {
    logic       is_long;
    logic [1:0] mode;
    logic       en;
  } ev_t;

  ev_t exp_q[$];
  ev_t ev;
  int  checks = 0;
  int  errors = 0;
  int  pushed = 0;
  int  seen = 0;
  logic [1:0] m_mode = 2'd0;
  logic       m_en = 1'b1;
  int  la;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic is_long);
    exp_q.push_back('{is_long, m_mode, m_en});
    pushed++;
  endtask

  task automatic hold_key(input int n, output int at);
    at = -1;
    key_n = 1'b0;
    for (int i = 1; i <= n + 14; i++) begin
      @(negedge clk);
      if (i == n) key_n = 1'b1;
      if (long_pulse && at < 0) at = i;
    end
  endtask

  always @(negedge clk) begin
    if (mode_pulse || long_pulse) begin
      seen++;
      chk("pulse_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        ev = exp_q.pop_front();
        chk("pulse_kind", {30'd0, long_pulse, mode_pulse},
            ev.is_long ? 32'd2 : 32'd1);
        chk("pulse_mode", 32'(mode), 32'(ev.mode));
        chk("pulse_en", 32'(led_en), 32'(ev.en));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    #100;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_mode", 32'(mode), 32'd0);
    chk("rst_en", 32'(led_en), 32'd1);
    chk("rst_mpulse", 32'(mode_pulse), 32'd0);
    chk("rst_lpulse", 32'(long_pulse), 32'd0);
    chk("rst_led", 32'(led_out), 32'h01);

    key_n = 1'b0;
    repeat (3) @(negedge clk);
    key_n = 1'b1;
    repeat (2) @(negedge clk);
    key_n = 1'b0;
    repeat (2) @(negedge clk);
    key_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("bounce_mode", 32'(mode), 32'd0);
    chk("bounce_pulses", 32'(seen), 32'd0);

    for (int k = 0; k < 4; k++) begin
      m_mode = (m_mode == 2'd3) ? 2'd0 : m_mode + 2'd1;
      push(1'b0);
      hold_key(10, la);
      chk("short_nolong", 32'(la < 0), 32'd1);
      chk("short_mode", 32'(mode), 32'(m_mode));
      chk("short_led", 32'(led_out), 32'(8'h01 << m_mode));
      chk("short_drained", 32'(exp_q.size()), 32'd0);
    end

    m_en = 1'b0;
    push(1'b1);
    hold_key(40, la);
    chk("long1_at", 32'(la), 32'd26);
    chk("long1_en", 32'(led_en), 32'd0);
    chk("long1_led", 32'(led_out), 32'h00);
    chk("long1_mode", 32'(mode), 32'(m_mode));
    chk("long1_drained", 32'(exp_q.size()), 32'd0);

    m_en = 1'b1;
    push(1'b1);
    hold_key(40, la);
    chk("long2_at", 32'(la), 32'd26);
    chk("long2_en", 32'(led_en), 32'd1);
    chk("long2_led", 32'(led_out), 32'(8'h01 << m_mode));
    chk("long2_drained", 32'(exp_q.size()), 32'd0);

    key_n = 1'b0;
    repeat (15) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    m_mode = 2'd0;
    m_en = 1'b1;
    chk("midrst_mode", 32'(mode), 32'd0);
    chk("midrst_en", 32'(led_en), 32'd1);
    m_en = 1'b0;
    push(1'b1);
    la = -1;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (long_pulse && la < 0) la = i;
    end
    key_n = 1'b1;
    repeat (14) @(negedge clk);
    chk("midrst_at", 32'(la), 32'd26);
    chk("midrst_en2", 32'(led_en), 32'd0);
    chk("midrst_drained", 32'(exp_q.size()), 32'd0);

    m_en = 1'b1;
    push(1'b1);
    hold_key(20, la);
    chk("edge_at", 32'(la), 32'd26);
    chk("edge_mode", 32'(mode), 32'(m_mode));
    chk("edge_en", 32'(led_en), 32'd1);
    chk("edge_drained", 32'(exp_q.size()), 32'd0);

    m_mode = (m_mode == 2'd3) ? 2'd0 : m_mode + 2'd1;
    push(1'b0);
    hold_key(19, la);
    chk("near_nolong", 32'(la < 0), 32'd1);
    chk("near_mode", 32'(mode), 32'(m_mode));
    chk("near_led", 32'(led_out), 32'(8'h01 << m_mode));
    chk("near_drained", 32'(exp_q.size()), 32'd0);

    chk("pulse_total", 32'(seen), 32'(pushed));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
